display_scan_ctrl: RTL

//  Scans six 7-segment digit slots, one slot per scan step. Shares one bcd splitter and one

---
 rtl/display_scan_ctrl_pkg.sv | 23 ++
 rtl/bcd.sv | 26 ++
 rtl/seven_segment.sv | 23 ++
 rtl/display_scan_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the six-digit display scanner.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package disp_defs;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam int         NUM_DIGITS = 6;
    localparam int         NUM_PAIRS  = 3;

    typedef enum logic {
        PAGE_TIME = 1'b0,
        PAGE_DATE = 1'b1
    } page_e;

    // Contents of the register between the splitter stage and the decode/write stage.
    typedef struct packed {
        logic       valid;
        logic [2:0] slot;
        logic [3:0] nibble;
        logic       over;
    } wr_stage_t;

endpackage

// File: rtl/bcd.sv
// Splits a two-digit field into tens and ones nibbles; flags values of 100 and above.
module bcd #(
    parameter int W = 7
) (
    input  logic [W-1:0] value,
    output logic [3:0]   tens,
    output logic [3:0]   ones,
    output logic         over
);

    logic [6:0] low7;

    always_comb begin
        low7 = value[6:0];
        over = (value >= W'(100));
        tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (low7 >= 7'(k * 10)) begin
                tens = 4'(k);
            end
        end
        // The true remainder is below 10, so modulo-16 arithmetic is exact.
        ones = low7[3:0] - tens * 4'd10;
    end

endmodule

// File: rtl/seven_segment.sv
// Decimal nibble to active-low seven-segment code; non-decimal nibbles show blank.
module seven_segment (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans six digit slots through one shared splitter and decoder into a registered digit buffer.
// Fields are snapshotted when slot 0 issues so a frame never mixes old and new values.
module display_scan_ctrl
    import disp_defs::*;
#(
    parameter int FIELD_W  = 7,
    parameter int SCAN_DIV = 1
) (
    input  logic                   CLOCK_24,
    input  logic                   RESET_N,
    input  logic                   en,
    input  logic                   page_sel,
    input  logic [3*FIELD_W-1:0]   time_fields,
    input  logic [3*FIELD_W-1:0]   date_fields,
    input  logic [2:0]             blink_mask,
    input  logic                   blink_phase,
    output logic [7*NUM_DIGITS-1:0] digit_seg,
    output logic                   frame_done
);

    localparam int            PW         = $clog2(SCAN_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]        presc_q, presc_d;
    logic [2:0]           slot_q, slot_d;
    logic [3*FIELD_W-1:0] snap_q, snap_d;
    wr_stage_t            s1_q, s1_d;
    logic [6:0]           digit_q [NUM_DIGITS];
    logic [6:0]           digit_d [NUM_DIGITS];
    logic                 frame_done_q, frame_done_d;

    logic                 issue;
    logic [3*FIELD_W-1:0] live_fields, frame_fields;
    logic [FIELD_W-1:0]   field;
    logic [3:0]           tens, ones;
    logic                 over;
    logic [6:0]           dec_seg, wr_code;
    logic                 blink_off;

    always_comb begin
        issue   = en && (presc_q == '0);
        presc_d = presc_q;
        if (en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
        slot_d = slot_q;
        if (issue) begin
            slot_d = (slot_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : slot_q + 3'd1;
        end
        live_fields  = (page_e'(page_sel) == PAGE_DATE) ? date_fields : time_fields;
        // Slot 0 reads the live fields directly; they become the snapshot for the rest of the frame.
        frame_fields = (slot_q == 3'd0) ? live_fields : snap_q;
        snap_d       = (issue && slot_q == 3'd0) ? live_fields : snap_q;
        case (slot_q[2:1])
            2'd0:    field = frame_fields[0 +: FIELD_W];
            2'd1:    field = frame_fields[FIELD_W +: FIELD_W];
            default: field = frame_fields[2*FIELD_W +: FIELD_W];
        endcase
    end

    bcd #(.W(FIELD_W)) u_bcd (
        .value (field),
        .tens  (tens),
        .ones  (ones),
        .over  (over)
    );

    always_comb begin
        s1_d.valid  = issue;
        s1_d.slot   = slot_q;
        s1_d.nibble = slot_q[0] ? ones : tens;
        s1_d.over   = over;
    end

    seven_segment u_seg (
        .bcd (s1_q.nibble),
        .seg (dec_seg)
    );

    always_comb begin
        case (s1_q.slot[2:1])
            2'd0:    blink_off = blink_mask[0] && !blink_phase;
            2'd1:    blink_off = blink_mask[1] && !blink_phase;
            default: blink_off = blink_mask[2] && !blink_phase;
        endcase
        // Blanking wins over the over-range dash.
        wr_code = blink_off ? SEG_BLANK : (s1_q.over ? SEG_DASH : dec_seg);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digit_d[d] = digit_q[d];
            if (s1_q.valid && s1_q.slot == 3'(d)) begin
                digit_d[d] = wr_code;
            end
        end
        frame_done_d = s1_q.valid && (s1_q.slot == 3'(NUM_DIGITS - 1));
    end

    always_ff @(posedge CLOCK_24) begin
        if (!RESET_N) begin
            presc_q      <= '0;
            slot_q       <= 3'd0;
            snap_q       <= '0;
            s1_q         <= '0;
            frame_done_q <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                digit_q[d] <= SEG_BLANK;
            end
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            snap_q       <= snap_d;
            s1_q         <= s1_d;
            frame_done_q <= frame_done_d;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                digit_q[d] <= digit_d[d];
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pins
        assign digit_seg[g*7 +: 7] = digit_q[g];
    end

    assign frame_done = frame_done_q;

endmodule
